// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM arbiter between instruction fetch and load/store
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   rdy                 global enable; low freezes all state and gates mem_wr
//   has_misbranch       speculative flush: aborts reads, blocks new requests
//   io_buffer_full      UART buffer full: holds off stores to I/O space
//   mem_din/mem_dout    RAM read byte (one-cycle latency) / write byte
//   mem_a, mem_wr       RAM byte address and write strobe
//   if_req/if_addr      fetch request; if_done pulse with if_data (32-bit word)
//   ls_req/ls_wr/ls_addr/ls_size/ls_wdata
//                       load/store request (size 00 byte, 01 half, 10 word);
//                       ls_done pulse with ls_rdata for loads
module mem_arbiter #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        has_misbranch,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  n_q, n_d;
    logic [31:0] a_q, a_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic [7:0]  dout_q, dout_d;
    logic        wr_q, wr_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;

    logic [31:0] merged;
    logic [2:0]  ls_n;
    logic        ls_io_blocked;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            n_q        <= 3'd0;
            a_q        <= 32'd0;
            wdata_q    <= 32'd0;
            buf_q      <= 32'd0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
            dout_q     <= 8'd0;
            wr_q       <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            a_q        <= a_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
            dout_q     <= dout_d;
            wr_q       <= wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        a_d        = a_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        dout_d     = dout_q;
        wr_d       = wr_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;

        case (ls_size)
            2'b00:   ls_n = 3'd1;
            2'b01:   ls_n = 3'd2;
            default: ls_n = 3'd4;
        endcase
        ls_io_blocked = ls_wr && (ls_addr[17:16] == IO_HI) && io_buffer_full;

        // cnt is the index of the address being presented; the byte arriving
        // on mem_din this cycle belongs to index cnt-1.
        merged = buf_q;
        if (cnt_q != 3'd0) begin
            merged[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
        end

        case (state_q)
            IDLE: begin
                // A done cycle is also an IDLE cycle but never accepts work.
                if (!has_misbranch && !if_done_q && !ls_done_q) begin
                    if (ls_req) begin
                        // A blocked I/O store still owns the bus: fetch waits too.
                        if (!ls_io_blocked) begin
                            state_d = ls_wr ? LS_WR : LS_RD;
                            a_d     = ls_addr;
                            cnt_d   = 3'd0;
                            n_d     = ls_n;
                            buf_d   = 32'd0;
                            wdata_d = ls_wdata;
                            if (ls_wr) begin
                                wr_d   = 1'b1;
                                dout_d = ls_wdata[7:0];
                            end
                        end
                    end else if (if_req) begin
                        state_d = IF_RD;
                        a_d     = if_addr;
                        cnt_d   = 3'd0;
                        n_d     = 3'd4;
                        buf_d   = 32'd0;
                    end
                end
            end
            IF_RD, LS_RD: begin
                if (has_misbranch) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    buf_d = merged;
                    if (cnt_q == n_q) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                        if (state_q == IF_RD) begin
                            if_done_d = 1'b1;
                            if_data_d = merged;
                        end else begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = merged;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        a_d   = a_q + 32'd1;
                    end
                end
            end
            LS_WR: begin
                // Stores are committed: the flush is deliberately ignored here.
                if (cnt_q == n_q - 3'd1) begin
                    state_d   = IDLE;
                    cnt_d     = 3'd0;
                    wr_d      = 1'b0;
                    dout_d    = 8'd0;
                    ls_done_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 3'd1;
                    a_d    = a_q + 32'd1;
                    dout_d = wdata_q[{cnt_q[1:0] + 2'd1, 3'b000} +: 8];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // During a stall the byte due this cycle is lost, so the address of that
    // pending byte is shown again; the RAM returns it in the resume cycle.
    assign mem_a    = (!rdy && (state_q == IF_RD || state_q == LS_RD) && cnt_q != 3'd0)
                      ? a_q - 32'd1 : a_q;
    assign mem_wr   = wr_q & rdy;
    assign mem_dout = dout_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule
